pin_entry: RTL

Keypad-side PIN entry block for the parking gate controller. It assembles two hex keypad nibbles into the 8-bit `password` word, drives the single-cycle `enter` strobe that the controller samples, and locks out entry while the controller signals a PIN alarm. It sits between the keypad scanner and the controller's `password`/`enter`/`pinAlarm` interface.

---
 rtl/pin_entry.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/pin_entry.sv
// Keypad PIN entry: two hex nibbles -> password, single-cycle enter strobe, alarm lockout; outputs registered, zero extra latency.
// Optional idle timeout of partial entries enabled by defining PIN_ENTRY_TIMEOUT_EN.
module pin_entry #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int LOCKOUT_CYCLES = 256
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [4:0] key_code,
    input  logic       pinAlarm,
    output logic [7:0] password,
    output logic       enter,
    output logic [1:0] digit_count,
    output logic       locked,
    output logic       timeout_err
);

    localparam int LW = (LOCKOUT_CYCLES > 2) ? $clog2(LOCKOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ONE  = 3'd1,
        S_TWO  = 3'd2,
        S_SEND = 3'd3,
        S_LOCK = 3'd4
    } state_t;

    state_t         r_state, w_state;
    logic [7:0]     r_sr, w_sr;
    logic [7:0]     r_pwd, w_pwd;
    logic           r_kv;
    logic           r_enter, w_enter;
    logic [1:0]     r_dcnt, w_dcnt;
    logic           r_locked, w_locked;
    logic [LW-1:0]  r_lock_cnt, w_lock_cnt;
    logic           w_press, w_is_digit, w_is_enter, w_is_clear;
    logic           w_to_hit;

`ifdef PIN_ENTRY_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0]  r_idle_cnt, w_idle_cnt;
    logic           r_terr;

    assign w_to_hit = ((r_state == S_ONE) || (r_state == S_TWO)) &&
                      (r_idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Any press restarts the idle window; outside ONE/TWO the counter rests at zero.
    always_comb begin
        w_idle_cnt = r_idle_cnt + 1'b1;
        if (w_press || !((w_state == S_ONE) || (w_state == S_TWO)))
            w_idle_cnt = '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_idle_cnt <= '0;
            r_terr     <= 1'b0;
        end else begin
            r_idle_cnt <= w_idle_cnt;
            r_terr     <= w_to_hit && !pinAlarm && !w_press;
        end
    end

    assign timeout_err = r_terr;
`else
    assign w_to_hit    = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign w_press    = key_valid & ~r_kv;
    assign w_is_digit = ~key_code[4];
    assign w_is_enter = (key_code == 5'h10);
    assign w_is_clear = (key_code == 5'h11);

    always_comb begin
        w_state    = r_state;
        w_sr       = r_sr;
        w_pwd      = r_pwd;
        w_enter    = 1'b0;
        w_lock_cnt = r_lock_cnt;
        case (r_state)
            S_IDLE, S_ONE, S_TWO: begin
                if (pinAlarm) begin
                    w_state    = S_LOCK;
                    w_sr       = 8'h00;
                    w_lock_cnt = LW'(LOCKOUT_CYCLES - 1);
                end else if (w_press) begin
                    if (w_is_digit) begin
                        w_sr    = {r_sr[3:0], key_code[3:0]};
                        w_state = (r_state == S_IDLE) ? S_ONE : S_TWO;
                    end else if (w_is_enter && (r_state == S_TWO)) begin
                        w_state = S_SEND;
                        w_pwd   = r_sr;
                        w_enter = 1'b1;
                    end else if (w_is_clear) begin
                        w_sr    = 8'h00;
                        w_state = S_IDLE;
                    end
                end else if (w_to_hit) begin
                    w_sr    = 8'h00;
                    w_state = S_IDLE;
                end
            end
            S_SEND: begin
                w_sr = 8'h00;
                if (pinAlarm) begin
                    w_state    = S_LOCK;
                    w_lock_cnt = LW'(LOCKOUT_CYCLES - 1);
                end else begin
                    w_state = S_IDLE;
                end
            end
            S_LOCK: begin
                // Alarm holds the counter at full; release only after a full quiet window.
                if (pinAlarm)
                    w_lock_cnt = LW'(LOCKOUT_CYCLES - 1);
                else if (r_lock_cnt == '0)
                    w_state = S_IDLE;
                else
                    w_lock_cnt = r_lock_cnt - 1'b1;
            end
            default: begin
                w_state = S_IDLE;
                w_sr    = 8'h00;
            end
        endcase
    end

    always_comb begin
        w_dcnt = 2'd0;
        case (w_state)
            S_ONE:   w_dcnt = 2'd1;
            S_TWO:   w_dcnt = 2'd2;
            default: w_dcnt = 2'd0;
        endcase
        w_locked = (w_state == S_LOCK);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_sr       <= 8'h00;
            r_pwd      <= 8'h00;
            r_kv       <= 1'b0;
            r_enter    <= 1'b0;
            r_dcnt     <= 2'd0;
            r_locked   <= 1'b0;
            r_lock_cnt <= '0;
        end else begin
            r_state    <= w_state;
            r_sr       <= w_sr;
            r_pwd      <= w_pwd;
            r_kv       <= key_valid;
            r_enter    <= w_enter;
            r_dcnt     <= w_dcnt;
            r_locked   <= w_locked;
            r_lock_cnt <= w_lock_cnt;
        end
    end

    assign password    = r_pwd;
    assign enter       = r_enter;
    assign digit_count = r_dcnt;
    assign locked      = r_locked;

endmodule
